// File: rtl/cmp_pkg.sv
// Shared definitions for the serial nibble comparator: FSM encodings and default operand size.
package cmp_pkg;

  localparam int DEFAULT_NIBBLES = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/comparator_4bit.sv
// Combinational 4-bit unsigned magnitude comparator; the single shared nibble datapath.
module comparator_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       gt,
  output logic       lt,
  output logic       eq
);

  assign gt = (a > b);
  assign lt = (a < b);
  assign eq = (a == b);

endmodule

// File: rtl/cmp_serial_ctrl.sv
// Serial unsigned comparator: walks operand nibbles MS-first through one 4-bit comparator,
// stopping at the first differing nibble.
module cmp_serial_ctrl
  import cmp_pkg::*;
#(
  parameter int NIBBLES = DEFAULT_NIBBLES
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [4*NIBBLES-1:0]       a,
  input  logic [4*NIBBLES-1:0]       b,
  output logic                       busy,
  output logic                       done,
  output logic                       gt,
  output logic                       lt,
  output logic                       eq,
  output logic [$clog2(NIBBLES):0]   count
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = $clog2(NIBBLES);
  localparam int CW = IW + 1;

  state_t          state_reg;
  state_t          state_next;
  logic [W-1:0]    a_reg;
  logic [W-1:0]    b_reg;
  logic [IW-1:0]   idx_reg;
  logic [CW-1:0]   exam_reg;

  logic [3:0]      a_nib [NIBBLES];
  logic [3:0]      b_nib [NIBBLES];
  logic [3:0]      nib_a;
  logic [3:0]      nib_b;
  logic            nib_gt;
  logic            nib_lt;
  logic            nib_eq;
  logic            last_nib;

  // Split the captured operands into nibble lanes for the index mux.
  genvar gi;
  generate
    for (gi = 0; gi < NIBBLES; gi++) begin : g_nib
      assign a_nib[gi] = a_reg[4*gi +: 4];
      assign b_nib[gi] = b_reg[4*gi +: 4];
    end
  endgenerate

  assign nib_a    = a_nib[idx_reg];
  assign nib_b    = b_nib[idx_reg];
  assign last_nib = (idx_reg == '0);

  comparator_4bit u_cmp (
    .a  (nib_a),
    .b  (nib_b),
    .gt (nib_gt),
    .lt (nib_lt),
    .eq (nib_eq)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = CMP;
      CMP:     if (!nib_eq || last_nib) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_reg)
      CMP:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Results are only written on the edge that leaves CMP, so they hold at all other times.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg    <= '0;
      b_reg    <= '0;
      idx_reg  <= '0;
      exam_reg <= '0;
      gt       <= 1'b0;
      lt       <= 1'b0;
      eq       <= 1'b0;
      count    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            a_reg    <= a;
            b_reg    <= b;
            idx_reg  <= IW'(NIBBLES - 1);
            exam_reg <= '0;
          end
        end
        CMP: begin
          exam_reg <= exam_reg + CW'(1);
          if (!nib_eq) begin
            gt    <= nib_gt;
            lt    <= nib_lt;
            eq    <= 1'b0;
            count <= exam_reg + CW'(1);
          end else if (last_nib) begin
            gt    <= 1'b0;
            lt    <= 1'b0;
            eq    <= 1'b1;
            count <= CW'(NIBBLES);
          end else begin
            idx_reg <= idx_reg - IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/cmp_serial_ctrl.md
CMP_SERIAL_CTRL -- requirements
Module: cmp_serial_ctrl

Interface
REQ-001 SHALL have parameter: NIBBLES, 4, number of 4-bit nibbles per operand; operand width W = 4*NIBBLES; NIBBLES >= 2.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: start  input  1  request a comparison; sampled only in IDLE.
REQ-005 SHALL have port: a  input  W  operand A, unsigned; captured when start is accepted.
REQ-006 SHALL have port: b  input  W  operand B, unsigned; captured when start is accepted.
REQ-007 SHALL have port: busy  output  1  high while in CMP.
REQ-008 SHALL have port: done  output  1  one-cycle pulse when a result is written.
REQ-009 SHALL have ports: gt, lt, eq  output  1 each  registered result: A>B, A<B, A==B.
REQ-010 SHALL have port: count  output  clog2(NIBBLES)+1  number of nibbles examined for the last result.

Function
REQ-011 SHALL implement FSM states IDLE, CMP, DONE.
REQ-012 SHALL, in IDLE with start=1, capture a/b into internal registers, set nibble index to NIBBLES-1 (MS nibble), clear the examined counter and go to CMP.
REQ-013 SHALL stay in IDLE when start=0; gt/lt/eq/count hold.
REQ-014 SHALL, each CMP cycle, compare exactly one nibble pair at the current index using one shared 4-bit comparator instance.
REQ-015 SHALL, on a nibble mismatch, write gt/lt from that nibble, eq=0, count=nibbles examined including the current one, and go to DONE.
REQ-016 SHALL, on a nibble match at index 0, write eq=1, gt=lt=0, count=NIBBLES, and go to DONE.
REQ-017 SHALL, on a nibble match at index >0, decrement the index and stay in CMP.
REQ-018 SHALL assert done for exactly the DONE cycle, then go to IDLE unconditionally.
REQ-019 SHALL make gt/lt/eq/count change only on the edge entering DONE; otherwise hold.
REQ-020 SHALL give latency k edges from the edge accepting start to the edge raising done, where k is the number of nibbles examined (1..NIBBLES).
REQ-021 SHALL ignore start in CMP and DONE; captured operands do not change mid-operation.
REQ-022 SHALL keep gt, lt and eq one-hot after the first done; all zero before it.
REQ-023 SHALL treat operand changes after capture as having no effect on the running comparison.

Reset
REQ-024 SHALL, on rst_n low, asynchronously force state=IDLE, busy=0, done=0, gt=lt=eq=0, count=0, operand and index registers=0.
REQ-025 SHALL, on reset mid-CMP, abort with no done pulse; the first start after rst_n rises behaves as from power-up.

Structure
REQ-026 SHALL place FSM state encodings (IDLE, CMP, DONE) and the default NIBBLES in shared package cmp_pkg.
REQ-027 SHALL instantiate exactly one sub-module, comparator_4bit (inputs a[3:0], b[3:0]; outputs gt, lt, eq), as the shared nibble datapath; the controller only muxes nibbles into it and sequences it.

Verification (NIBBLES=4)
REQ-028 SHALL check: a=16'h8000, b=16'h7FFF, start -> done 1 edge later, gt=1, lt=0, eq=0, count=1.
REQ-029 SHALL check: a=16'h12F0, b=16'h1300 -> done 2 edges later, lt=1, count=2.
REQ-030 SHALL check: a=16'h1234, b=16'h1235 -> done 4 edges later, lt=1, count=4; a=b=16'hABCD -> eq=1, count=4.
REQ-031 SHALL check: start held high with new operands (16'h0000 vs 16'hFFFF) during busy of a gt comparison -> ignored, gt result stands, next start accepted only from IDLE.
REQ-032 SHALL check: rst_n pulsed low in second CMP cycle of a=b=16'h5555 -> outputs zero immediately, no done; then a=16'h0001, b=16'h0000 -> gt=1, count=4.
